// File: rtl/mealy_seq_pkg.sv
// Shared types and elaboration-time helpers for the Mealy serial pattern
// detector. Everything here is evaluated with constant arguments only, so
// the transition table is fixed when the design is built.
package mealy_seq_pkg;

  localparam int MAX_PAT_W = 16;

  // Result of one prefix-extension step: new matched length and match flag.
  typedef struct packed {
    logic [4:0] next_len;
    logic       match;
  } prefix_res_t;

  // Width needed to hold a matched-prefix length of 0..pat_w-1.
  function automatic int st_width(input int pat_w);
    return (pat_w <= 2) ? 1 : $clog2(pat_w);
  endfunction

  // i-th bit of the pattern in arrival order (index 0 is the MSB).
  function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pattern,
                                   input int pat_w, input int i);
    return pattern[pat_w-1-i];
  endfunction

  // Does the length-k prefix of the pattern equal the last k bits of the
  // sequence "first s pattern bits, then b" (length s+1)?
  function automatic logic is_border(input logic [MAX_PAT_W-1:0] pattern,
                                     input int pat_w, input int s,
                                     input logic b, input int k);
    logic ok;
    ok = 1'b1;
    for (int j = 0; j < MAX_PAT_W; j++) begin
      if (j < k) begin
        int   pos;
        logic seq_bit;
        pos     = s + 1 - k + j;
        seq_bit = (pos == s) ? b : pat_bit(pattern, pat_w, pos);
        if (pat_bit(pattern, pat_w, j) != seq_bit) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Longest proper prefix of the whole pattern that is also its suffix.
  function automatic int fail_len(input logic [MAX_PAT_W-1:0] pattern,
                                  input int pat_w);
    int best;
    best = 0;
    for (int k = 1; k < MAX_PAT_W; k++) begin
      if (k < pat_w &&
          is_border(pattern, pat_w, pat_w - 1, pat_bit(pattern, pat_w, pat_w - 1), k))
        best = k;
    end
    return best;
  endfunction

  // Extend matched prefix s with bit b. On a full match next_len is the
  // overlap resume point; otherwise it is the KMP fallback length.
  function automatic prefix_res_t prefix_next(input logic [MAX_PAT_W-1:0] pattern,
                                              input int pat_w, input int s,
                                              input logic b);
    prefix_res_t res;
    int          best;
    res  = '0;
    best = 0;
    if (s == pat_w - 1 && b == pat_bit(pattern, pat_w, pat_w - 1)) begin
      res.match = 1'b1;
      best      = fail_len(pattern, pat_w);
    end else begin
      for (int k = 1; k <= MAX_PAT_W; k++) begin
        if (k <= s + 1 && k < pat_w && is_border(pattern, pat_w, s, b, k))
          best = k;
      end
    end
    res.next_len = 5'(best);
    return res;
  endfunction

endpackage

// File: rtl/seq_next_state.sv
// Combinational next-state lookup: a table indexed by {state, x} that is
// filled at elaboration from the pattern, then read with the live inputs.
module seq_next_state
  import mealy_seq_pkg::*;
#(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit              OVERLAP = 1'b1,
  parameter int              ST_W    = st_width(PAT_W)
) (
  input  logic [ST_W-1:0] state_i,
  input  logic            x_i,
  output logic [ST_W-1:0] next_state_o,
  output logic            match_o
);

  localparam int N = 2 ** (ST_W + 1);

  logic [N-1:0][ST_W-1:0] next_tbl;
  logic [N-1:0]           match_tbl;

  // Unreachable encodings (state >= PAT_W) map to state 0 with no match.
  for (genvar i = 0; i < N; i++) begin : g_tbl
    localparam int   S = i / 2;
    localparam logic B = 1'(i % 2);
    if (S < PAT_W) begin : g_legal
      localparam prefix_res_t R = prefix_next(16'(PATTERN), PAT_W, S, B);
      assign match_tbl[i] = R.match;
      assign next_tbl[i]  = (R.match && !OVERLAP) ? '0 : R.next_len[ST_W-1:0];
    end else begin : g_illegal
      assign match_tbl[i] = 1'b0;
      assign next_tbl[i]  = '0;
    end
  end

  assign next_state_o = next_tbl[{state_i, x_i}];
  assign match_o      = match_tbl[{state_i, x_i}];

endmodule

// File: rtl/mealy_seq_detector.sv
// Mealy serial pattern detector with input-valid qualifier, selectable
// overlap, a saturating match counter and a sticky overflow flag.
module mealy_seq_detector
  import mealy_seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8,
  parameter int               ST_W    = st_width(PAT_W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             x,
  output logic             y,
  output logic [ST_W-1:0]  state,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ST_W-1:0]  next_state;
  logic             match;

  seq_next_state #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .OVERLAP(OVERLAP),
    .ST_W   (ST_W)
  ) u_next (
    .state_i     (state_q),
    .x_i         (x),
    .next_state_o(next_state),
    .match_o     (match)
  );

  // Next-state, counter and overflow update; clear wins over en.
  always_comb begin
    // NOTE: every target gets a hold value first so no path infers a latch.
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (en) begin
      state_d = next_state;
      if (match) begin
        if (&count_q) ovf_d   = 1'b1;
        else          count_d = count_q + 1'b1;
      end
    end
  end

  // State, counter and overflow registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Zero-latency Mealy output, suppressed by reset, clear or an idle cycle.
  assign y        = en & ~clear & reset & match;
  assign state    = state_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule
